// File: rtl/world_pkg.sv
// Shared definitions for the pipe-cleaning world.
// Contents: cell codes, map geometry, robot orientation codes, the write-FSM
// state type, and helpers for map addressing and cell-code legality.
package world_pkg;

  typedef enum logic [2:0] {
    CELL_EMPTY   = 3'd0,
    CELL_WALL    = 3'd1,
    CELL_BARRIER = 3'd2,
    CELL_TRASH   = 3'd7
  } cell_t;

  typedef enum logic [1:0] {
    ORIENT_NORTH = 2'd0,
    ORIENT_SOUTH = 2'd1,
    ORIENT_EAST  = 2'd2,
    ORIENT_WEST  = 2'd3
  } orient_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_DONE = 2'd2
  } wr_state_t;

  localparam int MAP_ROWS = 10;
  localparam int MAP_COLS = 20;

  // Linear map address row*20 + col. The product is formed in 8 bits
  // because the largest address (10*20 + 20 = 220) does not fit in 6.
  function automatic logic [7:0] map_addr(input logic [5:0] row, input logic [5:0] col);
    logic [7:0] row8;
    logic [7:0] col8;
    row8 = {2'b00, row};
    col8 = {2'b00, col};
    return row8 * 8'(MAP_COLS) + col8;
  endfunction

  // Only empty, wall, barrier and trash may be written by the operator.
  function automatic logic is_legal_cell(input logic [2:0] code);
    logic legal;
    legal = 1'b0;
    case (code)
      CELL_EMPTY, CELL_WALL, CELL_BARRIER, CELL_TRASH: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/remote_controller_if.sv
// Map write port shared between the operator front-end and trash removal.
// The requester holds req/addr/data stable until the map owner answers with
// a single-cycle ack.
interface remote_controller_if;
  logic       map_wr_req;
  logic [7:0] map_wr_addr;
  logic [2:0] map_wr_data;
  logic       map_wr_ack;

  modport master (output map_wr_req, map_wr_addr, map_wr_data, input map_wr_ack);
  modport slave  (input map_wr_req, map_wr_addr, map_wr_data, output map_wr_ack);
endinterface

// File: rtl/input_debouncer.sv
// Button conditioner: 2-FF synchronizer, stability counter and rise pulse.
// A new level is accepted only after the synchronized input has differed
// from the accepted level for DEBOUNCE_CYCLES consecutive cycles; a
// one-cycle pulse marks each accepted low-to-high change. From a clean
// press the pulse appears 2 + DEBOUNCE_CYCLES cycles later.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock_50,
  input  logic reset_key,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the asynchronous button into the clock_50 domain.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level once it has persisted long enough; pulse on rises.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      stable_cnt <= '0;
      btn_level  <= 1'b0;
      btn_rise   <= 1'b0;
    end else begin
      btn_rise <= 1'b0;
      if (sync_q2 == btn_level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_cnt <= '0;
        btn_level  <= sync_q2;
        btn_rise   <= sync_q2;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/remote_controller.sv
// Operator front-end for the pipe-cleaning world.
// Converts buttons into cursor moves and single-cell map writes, and gates
// the robot step clock (free-run, single-step or paused). Map writes use a
// req/ack handshake because trash removal shares the same write port.
// Optional build macro REMOTE_AUTOREPEAT_EN: a held direction button repeats
// its move every REPEAT_CYCLES; without it each press moves exactly once.
module remote_controller #(
  parameter int ROWS            = 10,
  parameter int COLS            = 20,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_PERIOD     = 25000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic                clock_50,
  input  logic                reset_key,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_place,
  input  logic                btn_step,
  input  logic [2:0]          cmd_value,
  input  logic                cmd_run,
  output logic [5:0]          cursor_row,
  output logic [5:0]          cursor_col,
  remote_controller_if.master map,
  output logic                robot_tick,
  output logic                busy
);

  import world_pkg::*;

  localparam logic [5:0] ROW_MAX = 6'(ROWS);
  localparam logic [5:0] COL_MAX = 6'(COLS);
  localparam int         STEP_W  = $clog2(STEP_PERIOD + 1);

  // Button order: 0 up, 1 down, 2 left, 3 right, 4 place, 5 step.
  logic [5:0] raw_btn;
  logic [5:0] btn_level;
  logic [5:0] btn_rise;
  logic       unused_levels;

  logic [3:0] move_pulse;

  wr_state_t  state_q;
  wr_state_t  state_d;
  logic       place_ok;
  logic       load_wr;

  logic [STEP_W-1:0] period_cnt;
  logic              period_wrap;
  logic              tick_req;
  logic              pending_tick;

  assign raw_btn       = {btn_step, btn_place, btn_right, btn_left, btn_down, btn_up};
  assign unused_levels = ^btn_level;

  for (genvar i = 0; i < 6; i++) begin : g_debounce
    input_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock_50  (clock_50),
      .reset_key (reset_key),
      .btn_raw   (raw_btn[i]),
      .btn_level (btn_level[i]),
      .btn_rise  (btn_rise[i])
    );
  end

`ifdef REMOTE_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);

  logic [REP_W-1:0] repeat_cnt [4];
  logic [3:0]       repeat_pulse;

  // While a direction stays held, emit an extra move every REPEAT_CYCLES.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      for (int d = 0; d < 4; d++) begin
        repeat_cnt[d] <= '0;
      end
      repeat_pulse <= '0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        repeat_pulse[d] <= 1'b0;
        if (!btn_level[d]) begin
          repeat_cnt[d] <= '0;
        end else if (repeat_cnt[d] == REP_W'(REPEAT_CYCLES - 1)) begin
          repeat_cnt[d]   <= '0;
          repeat_pulse[d] <= 1'b1;
        end else begin
          repeat_cnt[d] <= repeat_cnt[d] + REP_W'(1);
        end
      end
    end
  end

  assign move_pulse = btn_rise[3:0] | repeat_pulse;
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;

  assign move_pulse = btn_rise[3:0];
`endif

  // Apply the highest-priority move, saturating at the map edges; the
  // cursor is frozen while a write is in flight so the latched address
  // always matches what the operator sees.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      cursor_row <= 6'd1;
      cursor_col <= 6'd1;
    end else if (!busy) begin
      if (move_pulse[0]) begin
        if (cursor_row > 6'd1) cursor_row <= cursor_row - 6'd1;
      end else if (move_pulse[1]) begin
        if (cursor_row < ROW_MAX) cursor_row <= cursor_row + 6'd1;
      end else if (move_pulse[2]) begin
        if (cursor_col > 6'd1) cursor_col <= cursor_col - 6'd1;
      end else if (move_pulse[3]) begin
        if (cursor_col < COL_MAX) cursor_col <= cursor_col + 6'd1;
      end
    end
  end

  assign place_ok = btn_rise[4] && is_legal_cell(cmd_value);

  // Write FSM state register.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state_q <= WR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write FSM next state plus handshake, busy and tick issue. A tick only
  // leaves in IDLE on a cycle that is not starting a write, so a write and
  // a tick never go out together.
  always_comb begin
    state_d        = state_q;
    load_wr        = 1'b0;
    busy           = 1'b1;
    map.map_wr_req = 1'b0;
    robot_tick     = 1'b0;
    unique case (state_q)
      WR_IDLE: begin
        busy = 1'b0;
        if (place_ok) begin
          state_d = WR_REQ;
          load_wr = 1'b1;
        end else begin
          robot_tick = tick_req || pending_tick;
        end
      end
      WR_REQ: begin
        map.map_wr_req = 1'b1;
        if (map.map_wr_ack) state_d = WR_DONE;
      end
      WR_DONE: begin
        state_d = WR_IDLE;
      end
      default: begin
        state_d = WR_IDLE;
      end
    endcase
  end

  // Latch the target cell and code when a write starts; held through REQ.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      map.map_wr_addr <= '0;
      map.map_wr_data <= '0;
    end else if (load_wr) begin
      map.map_wr_addr <= map_addr(cursor_row, cursor_col);
      map.map_wr_data <= cmd_value;
    end
  end

  // cmd_run is a quasi-static slide switch and is used without resampling.
  assign period_wrap = cmd_run && (period_cnt == STEP_W'(STEP_PERIOD - 1));
  assign tick_req    = period_wrap || (!cmd_run && btn_rise[5]);

  // Free-run period counter; parked at zero while paused.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      period_cnt <= '0;
    end else if (!cmd_run || period_wrap) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + STEP_W'(1);
    end
  end

  // Remember at most one tick that could not be issued yet.
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      pending_tick <= 1'b0;
    end else begin
      pending_tick <= (tick_req || pending_tick) && !robot_tick;
    end
  end

endmodule

// File: doc/remote_controller.md
Name: remote_controller

Overview:
Operator front-end for the pipe-cleaning world.
- Turns debounced push-buttons and switches into two things: cursor moves over the 10x20 map, and single-cell map writes (place wall, barrier or trash, or clear a cell).
- Gates the robot step clock: free-run, single-step, or paused.
- Sits between board I/O and the world's map write port and robot clock toggle. Shares the map write port with trash removal through a req/ack handshake.

Parameters:
ROWS, 10, map rows (valid row range 1..ROWS)
COLS, 20, map columns (valid column range 1..COLS)
DEBOUNCE_CYCLES, 250000, stable cycles needed before a button level is accepted (5 ms at 50 MHz)
STEP_PERIOD, 25000000, clock_50 cycles between robot ticks in run mode
REPEAT_CYCLES, 12500000, auto-repeat interval (used only with the optional feature)

Ports:
clock_50  in  1  system clock, 50 MHz
reset_key  in  1  asynchronous reset, active-low
btn_up, btn_down, btn_left, btn_right  in  1 each  raw active-high direction buttons
btn_place  in  1  raw active-high: write cmd_value to the cursor cell
btn_step  in  1  raw active-high: single robot tick when paused
cmd_value  in  3  cell code to place; legal codes are 0, 1, 2, 7
cmd_run  in  1  level switch: 1 = free-run, 0 = paused/step
cursor_row  out  6  current cursor row, 1..ROWS
cursor_col  out  6  current cursor column, 1..COLS
map_wr_req  out  1  map write request
map_wr_addr  out  8  row*20 + col
map_wr_data  out  3  cell code to write
map_wr_ack  in  1  one-cycle grant from the map owner
robot_tick  out  1  one-cycle pulse: world advances the robot clock by one toggle
busy  out  1  high while a write is outstanding

Behaviour:
- Reset (reset_key=0, async) forces:
  - cursor_row=1, cursor_col=1;
  - map_wr_req=0, map_wr_addr=0, map_wr_data=0;
  - robot_tick=0, busy=0;
  - FSM=IDLE; all counters 0; pending_tick=0.
- Every button passes through a 2-FF synchronizer, then the debouncer.
  - The debouncer emits a one-cycle rise pulse once the input has been stable high for DEBOUNCE_CYCLES.
  - Pulse latency from a clean press: 2 + DEBOUNCE_CYCLES cycles.
- Cursor moves:
  - up/down change the row by ±1 and saturate at 1/ROWS; left/right change the column by ±1 and saturate at 1/COLS.
  - Priority when several pulses arrive in one cycle: up > down > left > right. Only one move is applied; the others are dropped.
  - The cursor updates the cycle after the pulse.
  - Moves are dropped while busy=1.
- Write FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ on a place pulse when cmd_value is in {0,1,2,7}. On entry, latch map_wr_addr = cursor_row*20 + cursor_col and map_wr_data = cmd_value; set map_wr_req=1, busy=1.
  - Illegal codes 3..6: no transition, no write.
  - REQ: hold req, addr and data stable until map_wr_ack=1, then drop req -> DONE.
  - DONE: one cycle with busy=1 -> IDLE, busy=0.
  - Place pulses arriving while not in IDLE are dropped.
  - Address width: compute the product in at least 8 bits; the maximum address is 220.
- Robot tick:
  - Run mode (cmd_run=1): the period counter counts 0..STEP_PERIOD-1 and raises a tick request at wrap.
  - Paused (cmd_run=0): the period counter is held at 0; a step pulse raises a tick request. Step pulses in run mode are ignored.
  - A tick request while busy=1 sets pending_tick. robot_tick is issued the first cycle busy=0.
  - pending_tick holds at most one tick; further requests while pending are merged.
  - Switching cmd_run 1->0 clears the period counter but keeps pending_tick.
- A write and a tick are never issued in the same cycle.

Optional Feature:
REMOTE_AUTOREPEAT_EN:
- Defined: a direction held debounced-high for REPEAT_CYCLES generates another move pulse, then one more every REPEAT_CYCLES while it stays held. Release resets the repeat counter.
- Undefined: exactly one move per press. The repeat counter logic is absent.

Decomposition:
- Package world_pkg holds:
  - cell codes CELL_EMPTY=0, CELL_WALL=1, CELL_BARRIER=2, CELL_TRASH=7;
  - MAP_ROWS=10, MAP_COLS=20;
  - orientation codes north/south/east/west = 0/1/2/3;
  - function map_addr(row, col) = row*20 + col.
- One sub-module, input_debouncer (synchronizer + stability counter + rise pulse), instantiated once per button (6 instances).

Test Plan (bench uses DEBOUNCE_CYCLES=4, STEP_PERIOD=8, REPEAT_CYCLES=16):
- Reset, press btn_up 3 times and btn_left 2 times -> cursor stays (1,1); then 12 btn_down presses -> cursor_row saturates at 10.
- Cursor at (3,5), cmd_value=7, press place, map owner acks after 3 cycles -> req held 3 cycles with addr=65, data=7; busy falls 2 cycles after ack.
- cmd_value=4, press place -> no map_wr_req, busy stays 0.
- cmd_run=1, no writes -> robot_tick pulses every 8 cycles; start a write that stalls 10 cycles across two wraps -> exactly one tick, issued the cycle busy falls.
- cmd_run=0, press btn_step -> one tick pulse only; press step while cmd_run=1 -> no extra tick.
- Assert reset_key mid-REQ -> map_wr_req and busy drop to 0 immediately; cursor returns to (1,1).
